// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one AD9361 SPI bus among several masters.
// Ownership changes are separated by a guard gap; silent owners time out.
module spi_bus_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int GUARD_CYCLES = 4,
  parameter int TIMEOUT      = 1024,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  input  logic [NUM_REQ-1:0] m_sen,
  input  logic [NUM_REQ-1:0] m_sclk,
  input  logic [NUM_REQ-1:0] m_mosi,
  output logic [NUM_REQ-1:0] m_miso,
  output logic               spi_sen,
  output logic               spi_sclk,
  output logic               spi_mosi,
  input  logic               spi_miso,
  output logic [15:0]        timeout_cnt,
  output logic [OW-1:0]      owner
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN,
    S_GUARD
  } state_t;

  state_t             state;
  state_t             nxt;
  logic [1:0]         rst_sync;
  logic               arb_en;
  logic [GW-1:0]      gcnt;
  logic [TW-1:0]      tcnt;
  logic               found_hi;
  logic               found_lo;
  logic [OW-1:0]      idx_hi;
  logic [OW-1:0]      idx_lo;
  logic               win_found;
  logic [OW-1:0]      win_idx;
  logic [OW-1:0]      nxt_owner;
  logic               cur_sen;
  logic               cur_sclk;
  logic               cur_mosi;
  logic               own_hold;
  logic               tmo;
  logic [NUM_REQ-1:0] gnt_nxt;

  // Arbitration stays disabled until reset release has crossed two flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign arb_en   = rst_sync[1];
  assign cur_sen  = m_sen[owner];
  assign cur_sclk = m_sclk[owner];
  assign cur_mosi = m_mosi[owner];

  // Lowest index above the last owner wins, else lowest index overall
  always_comb begin : rr_pick
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (OW'(i) > owner) begin
          found_hi = 1'b1;
          idx_hi   = OW'(i);
        end else begin
          found_lo = 1'b1;
          idx_lo   = OW'(i);
        end
      end
    end
    win_found = found_hi | found_lo;
    win_idx   = found_hi ? idx_hi : idx_lo;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    tmo = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (arb_en && win_found) nxt = S_OWN;
      end
      S_OWN: begin
        if (!req[owner] && cur_sen) begin
          nxt = S_GUARD;
        end else if (cur_sen && tcnt == TW'(TIMEOUT - 1)) begin
          nxt = S_GUARD;
          tmo = 1'b1;
        end
      end
      S_GUARD: begin
        if (gcnt == GW'(GUARD_CYCLES - 1)) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    own_hold  = (state == S_OWN) && (nxt == S_OWN);
    nxt_owner = (state == S_IDLE) ? win_idx : owner;
    gnt_nxt   = '0;
    m_miso    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_nxt[i] = (nxt == S_OWN) && (nxt_owner == OW'(i));
      m_miso[i]  = (state == S_OWN) && (owner == OW'(i)) && spi_miso;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gcnt        <= '0;
      tcnt        <= '0;
      owner       <= OW'(NUM_REQ - 1);
      gnt         <= '0;
      spi_sen     <= 1'b1;
      spi_sclk    <= 1'b0;
      spi_mosi    <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      gcnt <= (state == S_GUARD) ? gcnt + GW'(1) : '0;
      if (state == S_IDLE && nxt == S_OWN) owner <= win_idx;
      // Silence counter runs only while the owner keeps sen high
      if (state != S_OWN || !cur_sen) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
      gnt <= gnt_nxt;
      if (own_hold) begin
        spi_sen  <= cur_sen;
        spi_sclk <= cur_sclk;
        spi_mosi <= cur_mosi;
      end else begin
        spi_sen  <= 1'b1;
        spi_sclk <= 1'b0;
        spi_mosi <= 1'b0;
      end
      if (tmo && timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
    end
  end

endmodule
